// File: rtl/fc_pkg.sv
// Shared definitions for the FIFO flow-control blocks: state encoding, dest field
// position and counter width, used by the sender, the flow-control FSM and benches.
package fc_pkg;

  localparam int FC_DATA_W = 6;
  localparam int FC_CNT_W  = 8;
  localparam int NDEST     = 4;
  localparam int DEST_MSB  = FC_DATA_W - 1;
  localparam int DEST_LSB  = FC_DATA_W - 2;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_ERR  = 2'd3
  } fc_state_t;

  function automatic logic [1:0] dest_of(input logic [FC_DATA_W-1:0] word);
    return word[DEST_MSB:DEST_LSB];
  endfunction

endpackage

// File: rtl/fc_pause_mask.sv
// Per-destination pause mask. A pause raised this cycle is folded into eff at once,
// and wins over a resume on the same bit.
module fc_pause_mask
  import fc_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [NDEST-1:0] pausa,
  input  logic [NDEST-1:0] continuar,
  output logic [NDEST-1:0] mask,
  output logic [NDEST-1:0] eff
);

  logic [NDEST-1:0] mask_reg;
  logic [NDEST-1:0] mask_next;

  assign mask_next = (mask_reg | pausa) & ~(continuar & ~pausa);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mask_reg <= '0;
    else       mask_reg <= mask_next;
  end

  assign mask = mask_reg;
  assign eff  = mask_reg | pausa;

endmodule

// File: rtl/fc_sender.sv
// Transmit side of the FIFO flow-control protocol: moves words from a show-ahead source
// FIFO to four dest FIFOs. Define FC_STATS_EN to add sent/stall statistics counters.
module fc_sender
  import fc_pkg::*;
#(
  parameter int DATA_W = FC_DATA_W
`ifdef FC_STATS_EN
  ,
  parameter int CNT_W  = FC_CNT_W
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              in_empty,
  input  logic [DATA_W-1:0] in_data,
  output logic              pop,
  input  logic [NDEST-1:0]  pausa,
  input  logic [NDEST-1:0]  continuar,
  input  logic              error_full,
  output logic [NDEST-1:0]  push,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              err
`ifdef FC_STATS_EN
  ,
  output logic [NDEST*CNT_W-1:0] sent_cnt,
  output logic [CNT_W-1:0]       stall_cnt
`endif
);

  fc_state_t         state_reg;
  logic [NDEST-1:0]  push_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic [NDEST-1:0]  mask;
  logic [NDEST-1:0]  eff;
  logic [NDEST-1:0]  dest_onehot;
  logic [1:0]        head_dest;
  logic              head_blocked;

  fc_pause_mask u_mask (
    .clk       (clk),
    .reset     (reset),
    .pausa     (pausa),
    .continuar (continuar),
    .mask      (mask),
    .eff       (eff)
  );

  assign head_dest    = in_data[DATA_W-1:DATA_W-2];
  assign head_blocked = eff[head_dest];

  genvar gi;
  generate
    for (gi = 0; gi < NDEST; gi++) begin : g_onehot
      assign dest_onehot[gi] = (head_dest == 2'(gi));
    end
  endgenerate

  // A blocked head stalls every destination; words are never reordered.
  assign pop = (state_reg == ST_RUN) & ~in_empty & ~head_blocked & ~error_full & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_INIT;
      push_reg     <= '0;
      out_data_reg <= '0;
    end else begin
      push_reg <= pop ? dest_onehot : '0;
      if (pop) out_data_reg <= in_data;
      if (error_full) begin
        state_reg <= ST_ERR;
      end else begin
        case (state_reg)
          ST_INIT: if (iniciar) state_reg <= ST_RUN;
          ST_RUN:  if (!in_empty && head_blocked) state_reg <= ST_HOLD;
          ST_HOLD: if (in_empty || !head_blocked) state_reg <= ST_RUN;
          ST_ERR:  state_reg <= ST_ERR;
          default: state_reg <= ST_INIT;
        endcase
      end
    end
  end

  assign push     = push_reg;
  assign out_data = out_data_reg;
  assign busy     = (state_reg == ST_RUN) & (pop | (|push_reg));
  assign err      = (state_reg == ST_ERR);

`ifdef FC_STATS_EN
  logic [CNT_W-1:0] stall_reg;

  generate
    for (gi = 0; gi < NDEST; gi++) begin : g_sent
      logic [CNT_W-1:0] sent_reg;
      always_ff @(posedge clk or posedge reset) begin
        if (reset)                             sent_reg <= '0;
        else if (push_reg[gi] && !(&sent_reg)) sent_reg <= sent_reg + 1'b1;
      end
      assign sent_cnt[gi*CNT_W +: CNT_W] = sent_reg;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                      stall_reg <= '0;
    else if (state_reg == ST_HOLD && !(&stall_reg)) stall_reg <= stall_reg + 1'b1;
  end

  assign stall_cnt = stall_reg;
`endif

endmodule

// File: tb/tb_fc_sender.sv
// Self-checking bench for fc_sender: directed vectors, corner sequences and a random
// stream checked cycle by cycle against a behavioural model of the protocol rules.
module tb_fc_sender;
  import fc_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       iniciar;
  logic       in_empty;
  logic [5:0] in_data;
  logic       pop;
  logic [3:0] pausa;
  logic [3:0] continuar;
  logic       error_full;
  logic [3:0] push;
  logic [5:0] out_data;
  logic       busy;
  logic       err;
`ifdef FC_STATS_EN
  logic [31:0] sent_cnt;
  logic [7:0]  stall_cnt;
`endif

  fc_sender dut (
    .clk        (clk),
    .reset      (reset),
    .iniciar    (iniciar),
    .in_empty   (in_empty),
    .in_data    (in_data),
    .pop        (pop),
    .pausa      (pausa),
    .continuar  (continuar),
    .error_full (error_full),
    .push       (push),
    .out_data   (out_data),
    .busy       (busy),
    .err        (err)
`ifdef FC_STATS_EN
    ,
    .sent_cnt   (sent_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: mode 0=waiting for start, 1=running, 2=held by pause, 3=fatal error.
  logic [5:0] src_q[$];
  int         m_mode;
  logic [3:0] m_mask;
  logic [3:0] m_push;
  logic [5:0] m_out;
  logic       l_pop;
  logic [3:0] l_push;
  logic [5:0] l_out;

  typedef struct {
    logic [5:0] word;
    logic [3:0] exp_push;
  } vec_t;
  vec_t tv[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_mask = '0;
    m_push = '0;
    m_out  = '0;
  endtask

  // One clock cycle; entered and left just after a rising edge.
  task automatic step();
    logic [3:0] eff;
    logic [1:0] d;
    bit         e_pop;
    in_empty = (src_q.size() == 0);
    in_data  = in_empty ? 6'h00 : src_q[0];
    eff      = m_mask | pausa;
    d        = in_data[5:4];
    e_pop    = (m_mode == 1) && !in_empty && !eff[d] && !error_full;
    @(negedge clk);
    l_pop  = pop;
    l_push = push;
    l_out  = out_data;
    check("pop", 32'(pop), 32'(e_pop));
    check("push", 32'(push), 32'(m_push));
    if (m_push != 0) check("out_data", 32'(out_data), 32'(m_out));
    check("busy", 32'(busy), 32'((m_mode == 1) && (e_pop || m_push != 0)));
    check("err", 32'(err), 32'(m_mode == 3));
    if (e_pop) $display("pop word %h -> dest %0d", in_data, d);
    @(posedge clk);
    if (error_full) m_mode = 3;
    else if (m_mode == 0 && iniciar) m_mode = 1;
    else if (m_mode == 1 && !in_empty && eff[d]) m_mode = 2;
    else if (m_mode == 2 && (in_empty || !eff[d])) m_mode = 1;
    m_mask = (m_mask | pausa) & ~(continuar & ~pausa);
    m_push = e_pop ? (4'b0001 << d) : 4'b0000;
    if (e_pop) begin
      m_out = in_data;
      void'(src_q.pop_front());
    end
    #1;
  endtask

  task automatic clear_inputs();
    iniciar    = 1'b0;
    pausa      = '0;
    continuar  = '0;
    error_full = 1'b0;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    clear_inputs();
    src_q.delete();
    in_empty = 1'b1;
    in_data  = '0;
    #1;
    check("rst_push", 32'(push), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err), 0);
    check("rst_pop", 32'(pop), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic start();
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
  endtask

  task automatic wait_push(input string name, input logic [3:0] exp_p, input logic [5:0] exp_d);
    bit seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      step();
      if (l_push != 0) seen = 1;
    end
    check({name, "_seen"}, 32'(seen), 1);
    check({name, "_push"}, 32'(l_push), 32'(exp_p));
    check({name, "_data"}, 32'(l_out), 32'(exp_d));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pushes;
    model_reset();
    reset = 1'b1;
    clear_inputs();
    in_empty = 1'b1;
    in_data  = '0;
    @(posedge clk);
    #1;
    reset_dut();

    // Basic stream, one word per destination, back to back.
    tv[0] = '{6'h05, 4'b0001};
    tv[1] = '{6'h16, 4'b0010};
    tv[2] = '{6'h2A, 4'b0100};
    tv[3] = '{6'h3F, 4'b1000};
    for (int i = 0; i < 4; i++) src_q.push_back(tv[i].word);
    start();
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      check("t1_push", 32'(l_push), 32'(tv[i].exp_push));
      check("t1_data", 32'(l_out), 32'(tv[i].word));
    end
    step();

    // Pause raised on the head's destination blocks it the same cycle.
    src_q.push_back(6'h16);
    pausa = 4'b0010;
    step();
    check("t2_pop_blocked", 32'(l_pop), 0);
    pausa = '0;
    step();
    step();
    continuar = 4'b0010;
    step();
    continuar = '0;
    wait_push("t2", 4'b0010, 6'h16);

    // Pause and resume on the same bit in one cycle: pause wins.
    src_q.push_back(6'h2A);
    pausa     = 4'b0100;
    continuar = 4'b0100;
    step();
    pausa     = '0;
    continuar = '0;
    pushes = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (l_push != 0) pushes++;
    end
    check("t3_blocked_pushes", 32'(pushes), 0);
    continuar = 4'b0100;
    step();
    continuar = '0;
    wait_push("t3", 4'b0100, 6'h2A);

    // Fatal error during a stream.
    src_q.push_back(6'h01);
    src_q.push_back(6'h12);
    src_q.push_back(6'h23);
    src_q.push_back(6'h34);
    step();
    step();
    error_full = 1'b1;
    step();
    check("t4_pop_on_error", 32'(l_pop), 0);
    error_full = 1'b0;
    step();
    check("t4_err", 32'(err), 1);
    iniciar = 1'b1;
    pushes = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (l_push != 0) pushes++;
    end
    iniciar = 1'b0;
    check("t4_pushes_after_err", 32'(pushes), 0);
    check("t4_err_sticky", 32'(err), 1);
    reset_dut();
    check("t4_err_cleared", 32'(err), 0);

    // Asynchronous reset in the middle of a cycle with push active.
    src_q.push_back(6'h3F);
    start();
    step();
    check("t5_push_before", 32'(push), 32'(4'b1000));
    #1;
    reset = 1'b1;
    #1;
    check("t5_push_async", 32'(push), 0);
    check("t5_out_async", 32'(out_data), 0);
    reset_dut();

    // Random traffic against the model.
    start();
    for (int c = 0; c < 600; c++) begin
      if (src_q.size() < 4 && $urandom_range(0, 1) == 1) src_q.push_back(6'($urandom));
      pausa     = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      continuar = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      iniciar   = 1'($urandom);
      step();
    end
    clear_inputs();
    for (int c = 0; c < 12; c++) begin
      continuar = 4'b1111;
      step();
    end
    error_full = 1'b1;
    src_q.push_back(6'h00);
    step();
    error_full = 1'b0;
    for (int c = 0; c < 4; c++) step();

`ifdef FC_STATS_EN
    // Statistics: dest-0 counter saturates, stall counter counts HOLD cycles.
    reset_dut();
    for (int i = 0; i < 300; i++) src_q.push_back(6'(i % 16));
    start();
    for (int i = 0; i < 400 && src_q.size() != 0; i++) step();
    step();
    step();
    check("t6_sent0", 32'(sent_cnt[7:0]), 255);
    check("t6_sent_others", 32'(sent_cnt[31:8]), 0);
    src_q.push_back(6'h16);
    pausa = 4'b0010;
    step();
    pausa = '0;
    for (int i = 0; i < 8; i++) step();
    continuar = 4'b0010;
    step();
    continuar = '0;
    wait_push("t6_release", 4'b0010, 6'h16);
    check("t6_stall", 32'(stall_cnt), 10);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
